// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end driving the ICache CPU port.
// One outstanding read at a time; results queued with their PC for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        read_request,
    output logic [31:0] addr,
    input  logic        read_response,
    input  logic [31:0] read_data,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_next;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr_next;
    logic [31:0]   r_q_data [FIFO_DEPTH];
    logic [31:0]   r_q_pc   [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_room;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_addr_inc;

    // Queue bookkeeping: a redirect flushes and overrides push/pop
    always_comb begin
        w_flush       = redirect_valid;
        w_pop         = (r_count != '0) && instr_ready;
        w_push        = (r_state == S_REQ) && read_response
                        && !redirect_valid;
        w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
        if (w_flush) begin
            w_count_next = '0;
        end
        w_room        = (w_count_next < DEPTH_C);
        w_redirect_pc = {redirect_pc[31:2], 2'b00};
        w_addr_inc    = r_addr + 32'd4;
    end

    // Fetch FSM next-state, next PC/address and request output
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_addr_next     = r_addr;
        read_request    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_fetch_pc_next = w_redirect_pc;
                end else if (w_room) begin
                    w_addr_next  = r_fetch_pc;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                read_request = 1'b1;
                if (redirect_valid) begin
                    w_fetch_pc_next = w_redirect_pc;
                    w_state_next    = read_response ? S_IDLE
                                                    : S_DISCARD;
                end else if (read_response) begin
                    w_fetch_pc_next = w_addr_inc;
                    if (w_room) begin
                        w_addr_next = w_addr_inc;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                read_request = 1'b1;
                if (redirect_valid) begin
                    w_fetch_pc_next = w_redirect_pc;
                end
                if (read_response) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and outstanding request address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_VECTOR;
            r_addr     <= RESET_VECTOR;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_addr     <= w_addr_next;
        end
    end

    // Instruction queue storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            r_count <= w_count_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_q_data[r_wr_ptr] <= read_data;
                    r_q_pc[r_wr_ptr]   <= r_addr;
                    r_wr_ptr           <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    assign addr        = r_addr;
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_q_data[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a queue-level
// reference model of the fetch stream and cache handshake.
module tb_fetch_unit;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_request;
    logic [31:0] addr;
    logic        read_response = 1'b0;
    logic [31:0] read_data = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_unit #(
        .RESET_VECTOR(RV),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read_request  (read_request),
        .addr          (addr),
        .read_response (read_response),
        .read_data     (read_data),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        popped[$];
    logic [31:0] exp_fetch;
    bit          stale;
    int          n_checks = 0;
    int          n_fail = 0;
    int          ready_pct = 100;
    int          resp_pct = 100;
    int          redir_pct = 0;
    bit          rand_data = 1'b0;
    int          mark;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_fetch = RV;
        stale     = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        read_response  = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        check("rst_req", read_request, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_addr", addr, RV);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input bit rd_en, input logic [31:0] rd_pc);
        logic        p_req;
        logic [31:0] p_addr;
        logic        resp;
        logic        rdy;
        logic [31:0] dat;
        bit          pushed;
        bit          exp_req;
        ent_t        e;
        p_req  = read_request;
        p_addr = addr;
        resp   = p_req && ($urandom_range(99) < resp_pct);
        dat    = rand_data ? $urandom : (p_addr ^ K);
        rdy    = ($urandom_range(99) < ready_pct);
        read_response  = resp;
        read_data      = resp ? dat : $urandom;
        instr_ready    = rdy;
        redirect_valid = rd_en;
        redirect_pc    = rd_pc;
        @(posedge clk);
        #1;
        read_response  = 1'b0;
        redirect_valid = 1'b0;
        if (rd_en) begin
            mq.delete();
            exp_fetch = {rd_pc[31:2], 2'b00};
            stale     = p_req && !resp;
            exp_req   = p_req && !resp;
        end else begin
            pushed = 1'b0;
            if (rdy && mq.size() != 0) begin
                popped.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (p_req && resp) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    e.pc   = p_addr;
                    e.data = dat;
                    mq.push_back(e);
                    exp_fetch = p_addr + 32'd4;
                    pushed    = 1'b1;
                end
            end
            if (p_req && !resp) exp_req = 1'b1;
            else if (p_req && !pushed) exp_req = 1'b0;
            else exp_req = (mq.size() < DEPTH);
        end
        check("req", read_request, exp_req);
        if (exp_req && read_request) begin
            check("addr", addr,
                  (p_req && !resp) ? p_addr : exp_fetch);
        end
        check("valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("pc", instr_pc, mq[0].pc);
            check("data", instr_data, mq[0].data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        bit          rd;
        @(posedge clk);
        #1;

        // sequential run, one response per cycle
        do_reset();
        ready_pct = 100;
        resp_pct  = 100;
        mark      = popped.size();
        repeat (8) cycle(0, 0);
        for (int i = 0; i < 4; i++) begin
            check("a_have", popped.size() > mark + i, 1);
            if (popped.size() > mark + i) begin
                check("a_pc", popped[mark+i].pc, 32'(4 * i));
                check("a_data", popped[mark+i].data,
                      32'(4 * i) ^ K);
            end
        end

        // decode stalled: queue fills, fetch pauses, resumes at 0x10
        do_reset();
        ready_pct = 0;
        repeat (8) cycle(0, 0);
        check("b_full_req", read_request, 0);
        check("b_full_valid", instr_valid, 1);
        ready_pct = 100;
        cycle(0, 0);
        check("b_resume_req", read_request, 1);
        check("b_resume_addr", addr, 32'h10);
        repeat (8) cycle(0, 0);

        // redirect while request to 0x8 outstanding
        do_reset();
        ready_pct = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(read_request && addr == 32'h8)) cycle(0, 0);
        end
        check("c_reach", addr, 32'h8);
        resp_pct = 0;
        cycle(1, 32'h102);
        check("c_flush", instr_valid, 0);
        cycle(0, 0);
        resp_pct  = 100;
        ready_pct = 100;
        mark      = popped.size();
        repeat (8) cycle(0, 0);
        check("c_have", popped.size() > mark, 1);
        if (popped.size() > mark) begin
            check("c_pc", popped[mark].pc, 32'h100);
        end

        // redirect coincident with a response
        do_reset();
        repeat (3) cycle(0, 0);
        check("d_req", read_request, 1);
        cycle(1, 32'h40);
        mark = popped.size();
        repeat (8) cycle(0, 0);
        check("d_have", popped.size() > mark, 1);
        if (popped.size() > mark) begin
            check("d_pc", popped[mark].pc, 32'h40);
        end

        // two redirects while discarding
        do_reset();
        resp_pct = 0;
        repeat (2) cycle(0, 0);
        cycle(1, 32'h80);
        cycle(1, 32'h200);
        resp_pct = 100;
        mark     = popped.size();
        repeat (8) cycle(0, 0);
        check("e_have", popped.size() > mark, 1);
        if (popped.size() > mark) begin
            check("e_pc", popped[mark].pc, 32'h200);
        end

        // async reset with 3 entries queued
        do_reset();
        ready_pct = 0;
        for (int i = 0; i < 10; i++) begin
            if (mq.size() < 3) cycle(0, 0);
        end
        check("f_valid", instr_valid, 1);
        check("f_req", read_request, 1);
        do_reset();
        cycle(0, 0);
        check("f_req2", read_request, 1);
        check("f_addr", addr, RV);

        // randomized traffic
        rand_data = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ready_pct = $urandom_range(100);
                resp_pct  = 20 + $urandom_range(80);
                redir_pct = $urandom_range(8);
            end
            if (i == 1500) do_reset();
            rd  = ($urandom_range(99) < redir_pct);
            rpc = ($urandom_range(3) == 0)
                  ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                  : ($urandom & 32'h0000_0FFF);
            cycle(rd, rpc);
        end
        check("progress", popped.size() > 200, 1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: the initiator side of the ICache CPU port. It keeps a fetch PC, issues one cache read at a time, and pushes each returned word with its PC into a small instruction queue for decode. Decode redirects (branch/jump/trap) flush the queue; a cache transaction already in flight is completed and its data discarded. The block sits between the pipeline's decode stage and `ICache`.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: instruction queue entries; power of two, >= 2.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `read_request`  out  1  cache read request; held until `read_response`.
- `addr`  out  32  cache read address; stable while `read_request` is 1 and no response yet.
- `read_response`  in  1  one-cycle pulse; `read_data` valid in that cycle.
- `read_data`  in  32  instruction word from cache.
- `instr_valid`  out  1  queue non-empty.
- `instr_data`  out  32  queue head instruction.
- `instr_pc`  out  32  queue head PC.
- `instr_ready`  in  1  decode accepts head; pop when `instr_valid & instr_ready`.
- `redirect_valid`  in  1  one-cycle redirect strobe.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] forced to 0.

## Operation
- Registers: `state`, `fetch_pc` (next PC to request), `addr` (PC of outstanding request), queue storage/pointers/`count` (width log2(FIFO_DEPTH)+1).
- States:
  - S_IDLE: `read_request`=0. If `count_next` < FIFO_DEPTH and no redirect, latch `addr`<=`fetch_pc`, go S_REQ.
  - S_REQ: `read_request`=1. On `read_response` without redirect: push {`addr`, `read_data`}, `fetch_pc`<=`addr`+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0). If `count_next` < FIFO_DEPTH, `addr`<=`addr`+4 and stay S_REQ (back-to-back); else go S_IDLE.
  - S_REQ, redirect without response: `fetch_pc`<=`redirect_pc`&~3, flush, go S_DISCARD; `addr` unchanged.
  - S_REQ, redirect with response in same cycle: drop data, `fetch_pc`<=redirect, flush, go S_IDLE.
  - S_DISCARD: `read_request`=1, `addr` held. On `read_response`: drop data, go S_IDLE. Redirect here only updates `fetch_pc` (last wins) and flushes.
  - S_IDLE redirect: update `fetch_pc`, flush, stay S_IDLE one cycle.
- Queue: `count_next` = `count` + push - pop; flush forces 0 and overrides push and pop in that cycle. Push into a full queue cannot occur by construction. Pop on empty is ignored.
- `instr_valid` = (`count` != 0); `instr_data`/`instr_pc` combinational from head entry registers.

## Timing
- Reset (asynchronous, immediate): state S_IDLE, `fetch_pc`=`addr`=RESET_VECTOR, `read_request`=0, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, count 0, all entries 0. Any cache response in flight at reset is lost.
- First rising edge with `reset`=1: enter S_REQ; `read_request`=1, `addr`=RESET_VECTOR.
- Response seen at edge N: queue entry visible (`instr_valid`=1) after edge N; next request (`addr`+4) driven after edge N, so throughput up to 1 instr/cycle when the cache answers every cycle.
- Redirect at edge N: `instr_valid`=0 after edge N; first request to redirect PC after edge N+1 (from S_IDLE) or one cycle after the discarded response.
- Full queue: no request issued until a pop frees a slot; resume next cycle.

## Test plan
- Reset then run, memory word at A = A ^ 32'hA5A5_0000, `instr_ready`=1: queue emits PCs 0,4,8,C with data A5A5_0000, A5A5_0004, A5A5_0008, A5A5_000C, no gaps beyond cache latency.
- `instr_ready`=0: exactly 4 entries filled, `read_request` drops to 0, `addr`=0x10 next; set ready -> fetching resumes at 0x10, order preserved.
- Redirect to 0x102 while request to 0x8 outstanding: response for 0x8 discarded, `instr_valid`=0, next request `addr`=0x100, first output PC 0x100.
- Redirect to 0x40 coincident with a response: that data never appears; next output PC 0x40.
- Two redirects (0x80 then 0x200) during S_DISCARD: fetch restarts at 0x200 only.
- Assert `reset`=0 mid-transaction with 3 entries queued: outputs clear immediately; after release first `addr`=RESET_VECTOR.
